wb_sequencer: RTL and testbench

Write-back sequencer driving the register file's single write port (`dstM`/`valM`) from an execute/memory stage that retires up to two register writes (E and M) per instruction. Queues individual writes in a small FIFO and drains one per cycle. Presents a registered write command that the register file applies on the following clock edge. Exports per-source stall flags so decode can hold while a read operand still has a write in flight.

---
 rtl/wb_sequencer.sv | 106 ++++++++++
 tb/tb_wb_sequencer.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/wb_sequencer.sv
// Write-back sequencer: queues up to two retired register writes per transaction
// and drains them one per cycle onto the register file's single write port.
module wb_sequencer #(
  parameter int DEPTH = 4,
  parameter int NREG  = 6
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [3:0]               in_dstE,
  input  logic [31:0]              in_valE,
  input  logic [3:0]               in_dstM,
  input  logic [31:0]              in_valM,
  output logic [3:0]               dstM,
  output logic [31:0]              valM,
  input  logic [3:0]               srcA,
  input  logic [3:0]               srcB,
  output logic                     stallA,
  output logic                     stallB,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] m_addr;
  logic [CW-1:0] count_q, count_d;
  logic [3:0]    dst_out_q;
  logic [31:0]   val_out_q;
  logic [3:0]    fifo_dst_q [DEPTH];
  logic [31:0]   fifo_val_q [DEPTH];
  logic          accept, e_en, m_en, pop;
  logic [1:0]    n_add;
  logic [DEPTH-1:0] hit_a, hit_b;

  // Two free slots are always demanded so a two-write accept can never overflow.
  assign in_ready = (CW'(DEPTH) - count_q) >= CW'(2);
  assign accept   = in_valid && in_ready;
  assign e_en     = accept && (int'(in_dstE) < NREG);
  assign m_en     = accept && (int'(in_dstM) < NREG);
  assign pop      = (count_q != '0);
  assign n_add    = {1'b0, e_en} + {1'b0, m_en};
  assign m_addr   = wr_ptr_q + AW'(e_en);

  always_comb begin
    rd_ptr_d = rd_ptr_q + AW'(pop);
    wr_ptr_d = wr_ptr_q + AW'(n_add);
    count_d  = count_q + CW'(n_add) - CW'(pop);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      count_q   <= '0;
      dst_out_q <= 4'hF;
      val_out_q <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      if (pop) begin
        dst_out_q <= fifo_dst_q[rd_ptr_q];
        val_out_q <= fifo_val_q[rd_ptr_q];
      end else begin
        dst_out_q <= 4'hF;
        val_out_q <= '0;
      end
    end
  end

  // E and M land in adjacent slots, E first, so M wins on a shared destination.
  always_ff @(posedge clock) begin
    if (e_en) begin
      fifo_dst_q[wr_ptr_q] <= in_dstE;
      fifo_val_q[wr_ptr_q] <= in_valE;
    end
    if (m_en) begin
      fifo_dst_q[m_addr] <= in_dstM;
      fifo_val_q[m_addr] <= in_valM;
    end
  end

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_sb
      logic [AW-1:0] offset;
      logic          live;
      assign offset    = AW'(gi) - rd_ptr_q;
      assign live      = CW'(offset) < count_q;
      assign hit_a[gi] = live && (fifo_dst_q[gi] == srcA);
      assign hit_b[gi] = live && (fifo_dst_q[gi] == srcB);
    end
  endgenerate

  assign stallA = (int'(srcA) < NREG) && ((|hit_a) || (dst_out_q == srcA));
  assign stallB = (int'(srcB) < NREG) && ((|hit_b) || (dst_out_q == srcB));
  assign busy   = pop || (dst_out_q != 4'hF);
  assign count  = count_q;
  assign dstM   = dst_out_q;
  assign valM   = val_out_q;

endmodule

// File: tb/tb_wb_sequencer.sv
// Bench for wb_sequencer: directed vector table, reset-mid-drain sequence and
// random traffic checked against a queue-based reference model.
module tb_wb_sequencer;

  localparam int DEPTH = 4;
  localparam int NREG  = 6;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  in_dstE = 4'hF;
  logic [31:0] in_valE = '0;
  logic [3:0]  in_dstM = 4'hF;
  logic [31:0] in_valM = '0;
  logic [3:0]  dstM;
  logic [31:0] valM;
  logic [3:0]  srcA = 4'hF;
  logic [3:0]  srcB = 4'hF;
  logic        stallA, stallB, busy;
  logic [2:0]  count;

  int n_vec = 0;
  int n_err = 0;

  wb_sequencer #(.DEPTH(DEPTH), .NREG(NREG)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_dstE(in_dstE), .in_valE(in_valE),
    .in_dstM(in_dstM), .in_valM(in_valM),
    .dstM(dstM), .valM(valM),
    .srcA(srcA), .srcB(srcB),
    .stallA(stallA), .stallB(stallB),
    .busy(busy), .count(count)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        v;
    logic [3:0]  de;
    logic [31:0] ve;
    logic [3:0]  dm;
    logic [31:0] vm;
    logic [3:0]  sa, sb;
    logic [3:0]  x_dst;
    logic [31:0] x_val;
    logic [2:0]  x_cnt;
    logic        x_rdy, x_sa, x_sb, x_busy;
  } vec_t;

  typedef struct {
    logic [3:0]  d;
    logic [31:0] v;
  } ent_t;

  // Reference model: a plain queue of pending writes plus the presented write.
  ent_t        mq[$];
  logic [3:0]  m_dst = 4'hF;
  logic [31:0] m_val = '0;

  function automatic vec_t mk(int v, int de, int ve, int dm, int vm, int sa, int sb,
                              int xd, int xv, int xc, int xr, int xa, int xb, int xbz);
    vec_t r;
    r.v = v[0]; r.de = de[3:0]; r.ve = ve; r.dm = dm[3:0]; r.vm = vm;
    r.sa = sa[3:0]; r.sb = sb[3:0];
    r.x_dst = xd[3:0]; r.x_val = xv; r.x_cnt = xc[2:0];
    r.x_rdy = xr[0]; r.x_sa = xa[0]; r.x_sb = xb[0]; r.x_busy = xbz[0];
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_dst = 4'hF;
    m_val = '0;
  endtask

  task automatic model_step();
    ent_t e;
    int   sz;
    bit   acc;
    sz  = mq.size();
    acc = in_valid && ((DEPTH - sz) >= 2);
    if (sz > 0) begin
      e = mq.pop_front();
      m_dst = e.d;
      m_val = e.v;
    end else begin
      m_dst = 4'hF;
      m_val = '0;
    end
    if (acc) begin
      if (int'(in_dstE) < NREG) mq.push_back('{in_dstE, in_valE});
      if (int'(in_dstM) < NREG) mq.push_back('{in_dstM, in_valM});
    end
  endtask

  function automatic bit model_stall(input logic [3:0] s);
    if (int'(s) >= NREG) return 1'b0;
    if (m_dst == s) return 1'b1;
    foreach (mq[k]) if (mq[k].d == s) return 1'b1;
    return 1'b0;
  endfunction

  task automatic check_model(input string tag);
    chk({tag, " dstM"},    32'(dstM),     32'(m_dst));
    chk({tag, " valM"},    valM,          m_val);
    chk({tag, " count"},   32'(count),    32'(mq.size()));
    chk({tag, " in_ready"}, 32'(in_ready), 32'((DEPTH - mq.size()) >= 2));
    chk({tag, " busy"},    32'(busy),     32'((mq.size() > 0) || (m_dst != 4'hF)));
    chk({tag, " stallA"},  32'(stallA),   32'(model_stall(srcA)));
    chk({tag, " stallB"},  32'(stallB),   32'(model_stall(srcB)));
  endtask

  task automatic cycle();
    @(posedge clock);
    model_step();
    @(negedge clock);
  endtask

  vec_t tbl[23];

  initial begin
    tbl[0]  = mk(1, 2, 'h11, 15, 0,    2, 15,  15, 0,     1, 1, 1, 0, 1);
    tbl[1]  = mk(0, 15, 0, 15, 0,      2, 15,  2, 'h11,   0, 1, 1, 0, 1);
    tbl[2]  = mk(0, 15, 0, 15, 0,      2, 15,  15, 0,     0, 1, 0, 0, 0);
    tbl[3]  = mk(1, 1, 'hA, 3, 'hB,    3, 1,   15, 0,     2, 1, 1, 1, 1);
    tbl[4]  = mk(0, 15, 0, 15, 0,      3, 1,   1, 'hA,    1, 1, 1, 1, 1);
    tbl[5]  = mk(0, 15, 0, 15, 0,      3, 1,   3, 'hB,    0, 1, 1, 0, 1);
    tbl[6]  = mk(0, 15, 0, 15, 0,      3, 1,   15, 0,     0, 1, 0, 0, 0);
    tbl[7]  = mk(1, 4, 1, 4, 2,        4, 15,  15, 0,     2, 1, 1, 0, 1);
    tbl[8]  = mk(0, 15, 0, 15, 0,      4, 15,  4, 1,      1, 1, 1, 0, 1);
    tbl[9]  = mk(0, 15, 0, 15, 0,      4, 15,  4, 2,      0, 1, 1, 0, 1);
    tbl[10] = mk(0, 15, 0, 15, 0,      4, 15,  15, 0,     0, 1, 0, 0, 0);
    tbl[11] = mk(1, 5, 'h55, 15, 0,    5, 15,  15, 0,     1, 1, 1, 0, 1);
    tbl[12] = mk(0, 15, 0, 15, 0,      5, 15,  5, 'h55,   0, 1, 1, 0, 1);
    tbl[13] = mk(0, 15, 0, 15, 0,      5, 15,  15, 0,     0, 1, 0, 0, 0);
    tbl[14] = mk(1, 15, 'h99, 7, 'h77, 7, 15,  15, 0,     0, 1, 0, 0, 0);
    tbl[15] = mk(1, 0, 'h10, 1, 'h11,  15, 15, 15, 0,     2, 1, 0, 0, 1);
    tbl[16] = mk(1, 0, 'h20, 1, 'h21,  15, 15, 0, 'h10,   3, 0, 0, 0, 1);
    tbl[17] = mk(1, 0, 'h30, 1, 'h31,  15, 15, 1, 'h11,   2, 1, 0, 0, 1);
    tbl[18] = mk(1, 0, 'h40, 1, 'h41,  15, 15, 0, 'h20,   3, 0, 0, 0, 1);
    tbl[19] = mk(0, 15, 0, 15, 0,      15, 15, 1, 'h21,   2, 1, 0, 0, 1);
    tbl[20] = mk(0, 15, 0, 15, 0,      15, 15, 0, 'h40,   1, 1, 0, 0, 1);
    tbl[21] = mk(0, 15, 0, 15, 0,      15, 15, 1, 'h41,   0, 1, 0, 0, 1);
    tbl[22] = mk(0, 15, 0, 15, 0,      15, 15, 15, 0,     0, 1, 0, 0, 0);

    // Reset state
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    model_reset();
    chk("reset dstM", 32'(dstM), 32'hF);
    chk("reset valM", valM, 32'h0);
    chk("reset count", 32'(count), 32'h0);
    chk("reset in_ready", 32'(in_ready), 32'h1);
    chk("reset busy", 32'(busy), 32'h0);
    chk("reset stallA", 32'(stallA), 32'h0);
    chk("reset stallB", 32'(stallB), 32'h0);

    // Directed vector table, one clock edge per row
    for (int i = 0; i < 23; i++) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      in_valid = tbl[i].v;
      in_dstE = tbl[i].de; in_valE = tbl[i].ve;
      in_dstM = tbl[i].dm; in_valM = tbl[i].vm;
      srcA = tbl[i].sa; srcB = tbl[i].sb;
      cycle();
      chk({tag, " dstM"}, 32'(dstM), 32'(tbl[i].x_dst));
      chk({tag, " valM"}, valM, tbl[i].x_val);
      chk({tag, " count"}, 32'(count), 32'(tbl[i].x_cnt));
      chk({tag, " in_ready"}, 32'(in_ready), 32'(tbl[i].x_rdy));
      chk({tag, " stallA"}, 32'(stallA), 32'(tbl[i].x_sa));
      chk({tag, " stallB"}, 32'(stallB), 32'(tbl[i].x_sb));
      chk({tag, " busy"}, 32'(busy), 32'(tbl[i].x_busy));
      $display("%s: valid=%0d E=%0h/%0h M=%0h/%0h -> dstM=%0h valM=%0h count=%0d",
               tag, tbl[i].v, tbl[i].de, tbl[i].ve, tbl[i].dm, tbl[i].vm, dstM, valM, count);
    end

    // Reset asserted mid-drain with three writes queued
    in_valid = 1'b1;
    in_dstE = 4'd1; in_valE = 32'hA1; in_dstM = 4'd2; in_valM = 32'hA2;
    srcA = 4'd3; srcB = 4'd4;
    cycle();
    in_dstE = 4'd3; in_valE = 32'hA3; in_dstM = 4'd4; in_valM = 32'hA4;
    cycle();
    in_valid = 1'b0;
    check_model("prefill");
    #2 reset = 1'b1;
    model_reset();
    #1;
    chk("midrst dstM", 32'(dstM), 32'hF);
    chk("midrst valM", valM, 32'h0);
    chk("midrst count", 32'(count), 32'h0);
    chk("midrst in_ready", 32'(in_ready), 32'h1);
    chk("midrst busy", 32'(busy), 32'h0);
    chk("midrst stallA", 32'(stallA), 32'h0);
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    $display("reset mid-drain: dstM=%0h count=%0d", dstM, count);
    for (int i = 0; i < 4; i++) begin
      cycle();
      check_model($sformatf("postrst%0d", i));
    end

    // Random traffic against the reference model
    for (int i = 0; i < 600; i++) begin
      in_valid = ($urandom_range(0, 9) < 7);
      in_dstE  = ($urandom_range(0, 4) == 0) ? 4'hF : 4'($urandom_range(0, 7));
      in_dstM  = ($urandom_range(0, 4) == 0) ? 4'hF : 4'($urandom_range(0, 7));
      in_valE  = $urandom;
      in_valM  = $urandom;
      srcA     = 4'($urandom_range(0, 7));
      srcB     = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom_range(0, 7));
      cycle();
      check_model($sformatf("rnd%0d", i));
    end
    in_valid = 1'b0;
    for (int i = 0; i < DEPTH + 2; i++) begin
      cycle();
      check_model($sformatf("drain%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
